// File: rtl/fifosc_param_if.sv
// Producer/consumer bus of the fifosc_param single-clock FIFO.
// The master side issues requests; the slave side (the FIFO) returns data, flags and pulses.
interface fifosc_param_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 3
);
  logic                  flush;
  logic                  insert;
  logic                  remove;
  logic [DATA_WIDTH-1:0] di;
  logic [DATA_WIDTH-1:0] dout;
  logic                  empty;
  logic                  full;
  logic                  almost_empty;
  logic                  almost_full;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output flush, insert, remove, di,
    input  dout, empty, full, almost_empty, almost_full, count, overflow, underflow
  );

  modport slave (
    input  flush, insert, remove, di,
    output dout, empty, full, almost_empty, almost_full, count, overflow, underflow
  );
endinterface

// File: rtl/fifosc_param.sv
// Parametrised single-clock FIFO with occupancy count, threshold flags and overflow/underflow pulses.
// Define FIFOSC_PARAM_FWFT_EN for first-word-fall-through reads; default is a registered read.
module fifosc_param #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned ADDR_WIDTH    = 3,
  parameter int unsigned AFULL_THRESH  = 6,
  parameter int unsigned AEMPTY_THRESH = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  fifosc_param_if.slave bus
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned CW    = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wrptr;
  logic [ADDR_WIDTH-1:0] rdptr;
  logic [CW-1:0]         count_q;
  logic [CW-1:0]         count_nxt;
  logic                  empty_q;
  logic                  full_q;
  logic                  aempty_q;
  logic                  afull_q;
  logic                  ovf_q;
  logic                  udf_q;
  logic                  wr_ok;
  logic                  rd_ok;

  // Acceptance and next occupancy; flush forces the FIFO back to empty.
  always_comb begin
    wr_ok     = bus.insert & ~full_q;
    rd_ok     = bus.remove & ~empty_q;
    count_nxt = count_q;
    if (bus.flush) begin
      count_nxt = '0;
    end else if (wr_ok && !rd_ok) begin
      count_nxt = count_q + CW'(1);
    end else if (rd_ok && !wr_ok) begin
      count_nxt = count_q - CW'(1);
    end
  end

  // Flags are registered decodes of the next count so they always match count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrptr    <= '0;
      rdptr    <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      aempty_q <= 1'b1;
      afull_q  <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      count_q  <= count_nxt;
      empty_q  <= (count_nxt == '0);
      full_q   <= (count_nxt == CW'(DEPTH));
      aempty_q <= (count_nxt <= CW'(AEMPTY_THRESH));
      afull_q  <= (count_nxt >= CW'(AFULL_THRESH));
      if (bus.flush) begin
        wrptr <= '0;
        rdptr <= '0;
        ovf_q <= 1'b0;
        udf_q <= 1'b0;
      end else begin
        if (wr_ok) wrptr <= wrptr + ADDR_WIDTH'(1);
        if (rd_ok) rdptr <= rdptr + ADDR_WIDTH'(1);
        ovf_q <= bus.insert & full_q;
        udf_q <= bus.remove & empty_q;
      end
    end
  end

  // Storage array, intentionally without reset.
  always_ff @(posedge clk) begin
    if (wr_ok && !bus.flush) mem[wrptr] <= bus.di;
  end

`ifdef FIFOSC_PARAM_FWFT_EN
  assign bus.dout = mem[rdptr];
`else
  logic [DATA_WIDTH-1:0] dout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q <= '0;
    end else if (bus.flush) begin
      dout_q <= '0;
    end else if (rd_ok) begin
      dout_q <= mem[rdptr];
    end
  end

  assign bus.dout = dout_q;
`endif

  assign bus.count        = count_q;
  assign bus.empty        = empty_q;
  assign bus.full         = full_q;
  assign bus.almost_empty = aempty_q;
  assign bus.almost_full  = afull_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;

  // Threshold ordering must hold: AEMPTY < AFULL <= DEPTH.
  thresh_legal: assert property (@(posedge clk) disable iff (!rst_n)
    (AEMPTY_THRESH < AFULL_THRESH) && (AFULL_THRESH <= DEPTH));

endmodule

// File: tb/tb_fifosc_param.sv
// Scoreboard bench for fifosc_param: the driver queues hand-derived expectations,
// a negedge monitor pops and compares those that fall due on each cycle.
module tb_fifosc_param;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 3;

  localparam int F_COUNT = 0;
  localparam int F_DOUT  = 1;
  localparam int F_EMPTY = 2;
  localparam int F_FULL  = 3;
  localparam int F_AE    = 4;
  localparam int F_AF    = 5;
  localparam int F_OVF   = 6;
  localparam int F_UDF   = 7;

  typedef struct {
    int          due;
    int          fld;
    logic [31:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t sbq[$];

  fifosc_param_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  fifosc_param #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_THRESH(6), .AEMPTY_THRESH(1)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish, got cycle %0d required completion", cyc);
    $fatal(1);
  end

  function automatic string fname(int f);
    case (f)
      F_COUNT: return "count";
      F_DOUT:  return "dout";
      F_EMPTY: return "empty";
      F_FULL:  return "full";
      F_AE:    return "almost_empty";
      F_AF:    return "almost_full";
      F_OVF:   return "overflow";
      default: return "underflow";
    endcase
  endfunction

  function automatic logic [31:0] fval(int f);
    case (f)
      F_COUNT: return 32'(bus.count);
      F_DOUT:  return 32'(bus.dout);
      F_EMPTY: return 32'(bus.empty);
      F_FULL:  return 32'(bus.full);
      F_AE:    return 32'(bus.almost_empty);
      F_AF:    return 32'(bus.almost_full);
      F_OVF:   return 32'(bus.overflow);
      default: return 32'(bus.underflow);
    endcase
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cycle %0d: got 0x%0h required 0x%0h", name, cyc, act, req);
    end
  endtask

  // Monitor: compare every queued expectation that has fallen due.
  always @(negedge clk) begin
    while (sbq.size() > 0 && sbq[0].due <= cyc) begin
      exp_t e;
      e = sbq.pop_front();
      chk(fname(e.fld), fval(e.fld), e.val);
    end
  end

  task automatic expect_f(int f, logic [31:0] v);
    exp_t e;
    e.due = cyc + 1;
    e.fld = f;
    e.val = v;
    sbq.push_back(e);
  endtask

  // Registered read data is only checked in standard mode.
  task automatic expect_rd(logic [31:0] v);
`ifndef FIFOSC_PARAM_FWFT_EN
    expect_f(F_DOUT, v);
`endif
  endtask

  task automatic drive(bit ins, bit rem, bit fl, logic [DW-1:0] d);
    @(negedge clk);
    bus.insert = ins;
    bus.remove = rem;
    bus.flush  = fl;
    bus.di     = d;
  endtask

  task automatic expect_state(int cnt, bit e, bit f, bit ae, bit af);
    expect_f(F_COUNT, 32'(cnt));
    expect_f(F_EMPTY, 32'(e));
    expect_f(F_FULL,  32'(f));
    expect_f(F_AE,    32'(ae));
    expect_f(F_AF,    32'(af));
  endtask

  initial begin
    bus.insert = 1'b0;
    bus.remove = 1'b0;
    bus.flush  = 1'b0;
    bus.di     = '0;

    // Reset state, observed while rst_n is still low.
    drive(0, 0, 0, 8'h00);
    expect_state(0, 1, 0, 1, 0);
    expect_f(F_OVF, 0);
    expect_f(F_UDF, 0);
    expect_rd(0);
    drive(0, 0, 0, 8'h00);
    rst_n = 1'b1;

    // Fill to full, then one rejected insert.
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, 0, 8'(8'h10 + i));
      expect_state(i + 1, 0, (i == 7), (i + 1 <= 1), (i + 1 >= 6));
      expect_f(F_OVF, 0);
    end
    drive(1, 0, 0, 8'h18);
    expect_f(F_COUNT, 8);
    expect_f(F_OVF, 1);
    drive(0, 0, 0, 8'h00);
    expect_f(F_OVF, 0);
    expect_f(F_FULL, 1);

    // Drain in order, then one rejected remove.
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, 0, 8'h00);
      expect_rd(32'(8'h10 + i));
      expect_state(7 - i, (i == 7), 0, (7 - i <= 1), (7 - i >= 6));
      expect_f(F_UDF, 0);
    end
    drive(0, 1, 0, 8'h00);
    expect_f(F_UDF, 1);
    expect_f(F_COUNT, 0);
    expect_rd(8'h17);
    drive(0, 0, 0, 8'h00);
    expect_f(F_UDF, 0);

    // Concurrent access across pointer wrap.
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 8'(8'h20 + i));
      expect_f(F_COUNT, 32'(i + 1));
    end
    for (int i = 0; i < 20; i++) begin
      drive(1, 1, 0, 8'(8'h24 + i));
      expect_f(F_COUNT, 4);
      expect_rd(32'(8'h20 + i));
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 0, 8'h00);
      expect_f(F_COUNT, 32'(3 - i));
      expect_rd(32'(8'h34 + i));
    end

    // Simultaneous insert+remove at full and at empty.
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, 0, 8'(8'h40 + i));
      expect_f(F_COUNT, 32'(i + 1));
    end
    drive(1, 1, 0, 8'h48);
    expect_state(7, 0, 0, 0, 1);
    expect_f(F_OVF, 1);
    expect_rd(8'h40);
    for (int i = 0; i < 7; i++) begin
      drive(0, 1, 0, 8'h00);
      expect_rd(32'(8'h41 + i));
      expect_f(F_COUNT, 32'(6 - i));
    end
    drive(1, 1, 0, 8'h55);
    expect_state(1, 0, 0, 1, 0);
    expect_f(F_UDF, 1);
    expect_rd(8'h47);
    drive(0, 1, 0, 8'h00);
    expect_rd(8'h55);
    expect_f(F_COUNT, 0);

    // Flush with count=5 and a same-cycle insert.
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 0, 8'(8'h60 + i));
      expect_f(F_COUNT, 32'(i + 1));
    end
    drive(1, 0, 1, 8'h65);
    expect_state(0, 1, 0, 1, 0);
    expect_f(F_OVF, 0);
    expect_f(F_UDF, 0);
    expect_rd(0);
    drive(1, 0, 0, 8'h70);
    expect_f(F_COUNT, 1);
    drive(0, 1, 0, 8'h00);
    expect_rd(8'h70);
    expect_f(F_COUNT, 0);

    // Asynchronous reset in the middle of a burst.
    drive(1, 0, 0, 8'h80);
    expect_f(F_COUNT, 1);
    drive(1, 0, 0, 8'h81);
    expect_f(F_COUNT, 2);
    drive(1, 1, 0, 8'h82);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_count", 32'(bus.count), 0);
    chk("async_empty", 32'(bus.empty), 1);
    chk("async_full", 32'(bus.full), 0);
    chk("async_almost_empty", 32'(bus.almost_empty), 1);
    chk("async_almost_full", 32'(bus.almost_full), 0);
    chk("async_overflow", 32'(bus.overflow), 0);
    chk("async_underflow", 32'(bus.underflow), 0);
`ifndef FIFOSC_PARAM_FWFT_EN
    chk("async_dout", 32'(bus.dout), 0);
`endif
    drive(0, 0, 0, 8'h00);
    rst_n = 1'b1;
    drive(1, 0, 0, 8'h90);
    expect_f(F_COUNT, 1);
    drive(0, 1, 0, 8'h00);
    expect_rd(8'h90);
    expect_f(F_EMPTY, 1);

`ifdef FIFOSC_PARAM_FWFT_EN
    // First-word-fall-through: head visible the cycle after insert.
    drive(1, 0, 0, 8'hAA);
    expect_f(F_EMPTY, 0);
    expect_f(F_DOUT, 8'hAA);
    drive(1, 0, 0, 8'hBB);
    expect_f(F_DOUT, 8'hAA);
    drive(0, 1, 0, 8'h00);
    expect_f(F_DOUT, 8'hBB);
    expect_f(F_COUNT, 1);
    drive(0, 1, 0, 8'h00);
    expect_f(F_EMPTY, 1);
`endif

    drive(0, 0, 0, 8'h00);
    drive(0, 0, 0, 8'h00);
    drive(0, 0, 0, 8'h00);
    chk("scoreboard_drained", 32'(sbq.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
